// File: rtl/systolic_input_feeder.sv
// rtl/systolic_input_feeder.sv - FIFO-buffered, lane-skewed vector feeder for the 2x2 systolic array
// Optional bubble counter output is enabled by defining FEEDER_PERF_EN.
module systolic_input_feeder #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vec_valid,
  output logic                     vec_ready,
  input  logic [DATA_W-1:0]        vec_in0,
  input  logic [DATA_W-1:0]        vec_in1,
  input  logic                     vec_last,
  output logic                     array_start,
  output logic [DATA_W-1:0]        array_in0,
  output logic [DATA_W-1:0]        array_in1,
  output logic                     busy,
  output logic                     done,
`ifdef FEEDER_PERF_EN
  output logic [15:0]              bubble_cnt,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    DRAIN_C = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   in0_q, in0_d;
  logic [DATA_W-1:0]   in1_q, in1_d;
  logic [DATA_W-1:0]   skew_q, skew_d;
  logic [3:0]          drain_q, drain_d;
  logic                start_q, start_d;
  logic                done_q, done_d;

  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [EW-1:0]       head;
  logic [DATA_W-1:0]   head_in0;
  logic [DATA_W-1:0]   head_in1;
  logic                head_last;

  assign fifo_empty = (count_q == '0);
  assign vec_ready  = (count_q < DEPTH_C);
  assign push       = vec_valid && vec_ready;
  assign head       = mem_q[rd_ptr_q];
  assign head_in0   = head[EW-1 -: DATA_W];
  assign head_in1   = head[DATA_W:1];
  assign head_last  = head[0];

  // Storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {vec_in0, vec_in1, vec_last};
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    in0_d   = '0;
    skew_d  = '0;
    in1_d   = skew_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in1_d = '0;
        if (!fifo_empty) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          in0_d  = head_in0;
          skew_d = head_in1;
          if (head_last) begin
            state_d = DRAIN;
            drain_d = DRAIN_C;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    start_d = (state_d != IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      skew_q   <= '0;
      drain_q  <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      skew_q   <= skew_d;
      drain_q  <= drain_d;
      start_q  <= start_d;
      done_q   <= done_d;
    end
  end

`ifdef FEEDER_PERF_EN
  logic [15:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (state_q == IDLE && state_d == STREAM) begin
      bubble_d = '0;
    end else if (state_q == STREAM && fifo_empty && bubble_q != 16'hFFFF) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

  assign array_start = start_q;
  assign busy        = start_q;
  assign done        = done_q;
  assign array_in0   = in0_q;
  assign array_in1   = in1_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb/tb_systolic_input_feeder.sv - directed self-checking bench for systolic_input_feeder
module tb_systolic_input_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vec_valid = 1'b0;
  logic        vec_ready;
  logic [31:0] vec_in0 = '0;
  logic [31:0] vec_in1 = '0;
  logic        vec_last = 1'b0;
  logic        array_start;
  logic [31:0] array_in0;
  logic [31:0] array_in1;
  logic        busy;
  logic        done;
  logic [2:0]  fifo_count;
`ifdef FEEDER_PERF_EN
  logic [15:0] bubble_cnt;
`endif

  int checks = 0;
  int failures = 0;

  systolic_input_feeder #(.DATA_W(32), .DEPTH(4), .DRAIN_CYCLES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec_in0     (vec_in0),
    .vec_in1     (vec_in1),
    .vec_last    (vec_last),
    .array_start (array_start),
    .array_in0   (array_in0),
    .array_in1   (array_in1),
    .busy        (busy),
    .done        (done),
`ifdef FEEDER_PERF_EN
    .bubble_cnt  (bubble_cnt),
`endif
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic l);
    vec_valid = v;
    vec_in0   = a;
    vec_in1   = b;
    vec_last  = l;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!array_start && fifo_count == 3'd0 && !done) break;
      tick();
    end
    check("idle_reached", {62'd0, array_start, done}, 64'd0);
  endtask

  initial begin
    int exp0 [7];
    int exp1 [7];
    int exps [7];
    int expd [7];
    logic        done_hist [13];
    logic [31:0] in0_hist  [13];
    int nd, first_d, second_d;
    logic got_done;

    // Power-on reset
    tick();
    tick();
    check("por_count", fifo_count, 0);
    check("por_ready", vec_ready, 1);
    check("por_start", array_start, 0);
    check("por_done", done, 0);
    reset = 1'b1;
    tick();

    // Reset mid-stream with two entries buffered
    drive(1, 32'h11, 32'h12, 0); tick();
    drive(1, 32'h21, 32'h22, 0); tick();
    drive(1, 32'h31, 32'h32, 0); tick();
    drive(1, 32'h41, 32'h42, 0); tick();
    check("rst_pre_count", fifo_count, 2);
    check("rst_pre_start", array_start, 1);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check("rst_async_count", fifo_count, 0);
    check("rst_async_start", array_start, 0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_start", array_start, 0);
    check("rst_in0", array_in0, 0);
    check("rst_in1", array_in1, 0);
    check("rst_ready", vec_ready, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    tick();
    check("rst_stays_idle", array_start, 0);

    // Single batch without bubbles
    drive(1, 1, 2, 0); tick();
    check("sb_count1", fifo_count, 1);
    check("sb_start_e0", array_start, 0);
    drive(1, 3, 4, 0); tick();
    check("sb_start_e1", array_start, 1);
    check("sb_in0_e1", array_in0, 0);
    drive(1, 5, 6, 1); tick();
    drive(0, 0, 0, 0);
    exp0 = '{1, 3, 5, 0, 0, 0, 0};
    exp1 = '{0, 2, 4, 6, 0, 0, 0};
    exps = '{1, 1, 1, 1, 1, 0, 0};
    expd = '{0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      check($sformatf("sb_in0_%0d", i), array_in0, 64'(exp0[i]));
      check($sformatf("sb_in1_%0d", i), array_in1, 64'(exp1[i]));
      check($sformatf("sb_start_%0d", i), array_start, 64'(exps[i]));
      check($sformatf("sb_done_%0d", i), done, 64'(expd[i]));
      if (i < 6) tick();
    end
    wait_idle();

    // Bubble inside a batch
    drive(1, 7, 8, 0); tick();
    drive(0, 0, 0, 0); tick();
    check("bub_start_e1", array_start, 1);
    tick();
    exp0 = '{7, 0, 0, 9, 0, 0, 0};
    exp1 = '{0, 8, 0, 0, 10, 0, 0};
    exps = '{1, 1, 1, 1, 1, 1, 0};
    expd = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      check($sformatf("bub_in0_%0d", i), array_in0, 64'(exp0[i]));
      check($sformatf("bub_in1_%0d", i), array_in1, 64'(exp1[i]));
      check($sformatf("bub_start_%0d", i), array_start, 64'(exps[i]));
      check($sformatf("bub_done_%0d", i), done, 64'(expd[i]));
      if (i == 1) drive(1, 9, 10, 1);
      else drive(0, 0, 0, 0);
      if (i < 6) tick();
    end
`ifdef FEEDER_PERF_EN
    check("bub_cnt", bubble_cnt, 2);
`endif
    wait_idle();

    // FIFO full while the previous batch drains
    drive(1, 32'hA0, 32'hA1, 1); tick();
    drive(1, 32'hB1, 32'hC1, 0); tick();
    check("full_count_e1", fifo_count, 2);
    drive(1, 32'hB2, 32'hC2, 0); tick();
    check("full_count_e2", fifo_count, 2);
    drive(1, 32'hB3, 32'hC3, 0); tick();
    drive(1, 32'hB4, 32'hC4, 0); tick();
    check("full_count_e4", fifo_count, 4);
    check("full_ready_e4", vec_ready, 0);
    drive(1, 32'hB5, 32'hC5, 1); tick();
    check("full_done_e5", done, 1);
    check("full_count_e5", fifo_count, 4);
    tick();
    check("full_count_e6", fifo_count, 4);
    check("full_ready_e6", vec_ready, 0);
    tick();
    check("full_in0_e7", array_in0, 32'hB1);
    check("full_count_e7", fifo_count, 3);
    check("full_ready_e7", vec_ready, 1);
    tick();
    drive(0, 0, 0, 0);
    check("full_in0_e8", array_in0, 32'hB2);
    check("full_count_e8", fifo_count, 3);
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("full_done_seen", got_done, 1);
    check("full_last_in1", array_in1, 0);
    wait_idle();

    // Back-to-back single-vector batches
    drive(1, 32'hAA, 32'hAB, 1); tick();
    drive(1, 32'hBB, 32'hBC, 1); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      tick();
      done_hist[i] = done;
      in0_hist[i]  = array_in0;
    end
    nd = 0;
    first_d = -1;
    second_d = -1;
    for (int i = 0; i < 13; i++) begin
      if (done_hist[i]) begin
        if (nd == 0) first_d = i;
        else if (nd == 1) second_d = i;
        nd++;
      end
    end
    check("b2b_done_count", 64'(nd), 2);
    check("b2b_done_first", 64'(first_d), 3);
    check("b2b_done_second", 64'(second_d), 8);
    check("b2b_in0_a", in0_hist[0], 32'hAA);
    check("b2b_in0_gap", in0_hist[3], 0);
    check("b2b_in0_b", in0_hist[5], 32'hBB);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_input_feeder.md
Name: systolic_input_feeder

Overview:
- Upstream stage of the 2x2 systolic array.
- Buffers row vectors (lane0/lane1 pairs) from the host or memory side in a small FIFO.
- Streams the buffered vectors into the array's in0/in1 with the diagonal skew the array needs: lane1 arrives one cycle after lane0.
- Drives the array's start enable and signals completion once a batch has fully drained.

Parameters:
- DATA_W, 32, width of each lane value; matches the array's 32-bit datapath.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DRAIN_CYCLES, 3, cycles after the last vector during which start stays high so the array pipeline flushes; range 1..15.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous active-low reset; asserted when 0.
- vec_valid  input  1  upstream vector valid.
- vec_ready  output  1  feeder can accept a vector.
- vec_in0  input  DATA_W  lane0 value.
- vec_in1  input  DATA_W  lane1 value.
- vec_last  input  1  marks the final vector of a batch.
- array_start  output  1  enable to the array's start input.
- array_in0  output  DATA_W  to array in0.
- array_in1  output  DATA_W  to array in1, skewed +1 cycle.
- busy  output  1  FSM is not IDLE.
- done  output  1  one-cycle pulse at end of batch drain.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty. All outputs 0, except vec_ready=1. FSM=IDLE. Skew register=0. A reset mid-batch discards all buffered and in-flight data.
- FIFO entry = {in0, in1, last}.
- Push when vec_valid && vec_ready.
- vec_ready = (fifo_count < DEPTH), combinational from count. No bypass: when full, ready=0 even if a pop occurs in the same cycle.
- A simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo DEPTH.
- Pushes are accepted in every state, including DRAIN. Vectors pushed during DRAIN belong to the next batch.
- FSM states:
  - IDLE: array_start=0, array_in0=0, array_in1=0.
  - IDLE -> STREAM on the first edge where the FIFO is non-empty. Nothing is popped on that edge.
  - STREAM: pop one entry each edge the FIFO is non-empty. array_in0 <= entry.in0. skew_reg <= entry.in1. array_in1 <= skew_reg.
  - STREAM, FIFO empty (bubble): array_in0 <= 0, skew_reg <= 0, array_in1 <= skew_reg. Remain in STREAM with array_start=1.
  - STREAM -> DRAIN on the edge that pops an entry with last=1. Drain counter loads DRAIN_CYCLES.
  - DRAIN: array_in0 <= 0, skew_reg <= 0, array_in1 <= skew_reg. Counter decrements each edge, and there are no pops.
  - DRAIN -> IDLE on the edge where the counter equals 1. done=1 for exactly the following cycle.
- Registered outputs:
  - array_start = 1 exactly while the state is STREAM or DRAIN.
  - busy = array_start.
- Latency: an entry popped at edge t appears on array_in0 after edge t and on array_in1 after edge t+1. Pop-to-array_in0 latency is 1 cycle.
- Back-to-back batches: if the FIFO is non-empty when DRAIN exits, the FSM still spends one cycle in IDLE before re-entering STREAM. done pulses during that IDLE cycle.
- Arithmetic: no data arithmetic. Values pass through bit-exact.

Optional Feature:
- Macro: FEEDER_PERF_EN.
- When defined:
  - Adds output port bubble_cnt [15:0], which counts STREAM cycles in which the FIFO was empty.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on reset and on each IDLE->STREAM transition.
  - Holds its value in DRAIN and IDLE.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset check: hold reset=0 for 3 cycles mid-stream with 2 entries buffered -> after release, fifo_count=0, array_start=0, array_in0=array_in1=0, vec_ready=1, done=0.
- Single batch, no bubbles:
  - Stimulus: push (in0,in1) = (1,2), (3,4), then (5,6) with last=1, in consecutive cycles; DRAIN_CYCLES=3.
  - Expected array_in0 sequence: 1, 3, 5, 0, 0, 0.
  - Expected array_in1 sequence: 0, 2, 4, 6, 0, 0.
  - array_start high for 6 cycles. done pulses once, the cycle after array_start falls.
- FIFO full:
  - Hold vec_valid=1 while the FSM streams, with the pop side stalled because the array is still in a prior batch's DRAIN -> fifo_count reaches 4, vec_ready=0.
  - A fifth vector is held by upstream and accepted only after the first pop.
- Bubble:
  - Stimulus: push (7,8), wait 2 cycles, then push (9,10) with last=1.
  - Expected array_in0: 7, 0, 0, 9, then zeros.
  - Expected array_in1: one cycle behind array_in0.
  - array_start stays 1 through the bubble. With FEEDER_PERF_EN, bubble_cnt=2.
- Back-to-back batches: push batch A (1 vector, last=1) then immediately batch B (1 vector, last=1) -> two done pulses, separated by at least DRAIN_CYCLES+2 cycles. B's data appears on array_in0 only after A's DRAIN.
